// File: rtl/sprite_draw_sequencer_pkg.sv
// Shared definitions for the sprite draw sequencer: FSM state encoding,
// pixel field widths and the slot-index width helper.
package sprite_draw_sequencer_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_ERASE_REQ  = 3'd1;
    localparam logic [2:0] ST_ERASE_WAIT = 3'd2;
    localparam logic [2:0] ST_DRAW_REQ   = 3'd3;
    localparam logic [2:0] ST_DRAW_WAIT  = 3'd4;
    localparam logic [2:0] ST_ADVANCE    = 3'd5;
    localparam logic [2:0] ST_DONE       = 3'd6;

    localparam int X_W = 9;
    localparam int Y_W = 8;
    localparam int C_W = 3;

    // A single-slot build still needs a 1-bit index.
    function automatic int slot_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sprite_draw_sequencer_pixel_mux.sv
// sprite_pixel_mux: registers the selected slot's pixel onto the VGA stream
// while that slot holds a request; plot is forced low otherwise.
module sprite_pixel_mux
    import sprite_draw_sequencer_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int SW          = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         active,
    input  logic [SW-1:0]                sel,
    input  logic [X_W*NUM_SPRITES-1:0]   spr_x,
    input  logic [Y_W*NUM_SPRITES-1:0]   spr_y,
    input  logic [C_W*NUM_SPRITES-1:0]   spr_colour,
    input  logic [NUM_SPRITES-1:0]       spr_plot,
    output logic [X_W-1:0]               vga_x,
    output logic [Y_W-1:0]               vga_y,
    output logic [C_W-1:0]               vga_colour,
    output logic                         vga_plot
);

    logic [X_W-1:0] x_sel;
    logic [Y_W-1:0] y_sel;
    logic [C_W-1:0] c_sel;
    logic           p_sel;

    always_comb begin
        x_sel = '0;
        y_sel = '0;
        c_sel = '0;
        p_sel = 1'b0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (sel == SW'(i)) begin
                x_sel = spr_x[i*X_W +: X_W];
                y_sel = spr_y[i*Y_W +: Y_W];
                c_sel = spr_colour[i*C_W +: C_W];
                p_sel = spr_plot[i];
            end
        end
    end

    // Coordinates hold their last value between requests; only plot is gated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else if (active) begin
            vga_x      <= x_sel;
            vga_y      <= y_sel;
            vga_colour <= c_sel;
            vga_plot   <= p_sel;
        end else begin
            vga_plot   <= 1'b0;
        end
    end

endmodule

// File: rtl/sprite_draw_sequencer.sv
// sprite_draw_sequencer: per frame, erases then draws every enabled sprite slot
// in order, one engine request at a time. Define SEQ_TIMEOUT_EN for the watchdog.
module sprite_draw_sequencer
    import sprite_draw_sequencer_pkg::*;
#(
    parameter int NUM_SPRITES    = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_tick,
    input  logic [NUM_SPRITES-1:0]       sprite_en,
    output logic [NUM_SPRITES-1:0]       erase_req,
    output logic [NUM_SPRITES-1:0]       draw_req,
    input  logic [NUM_SPRITES-1:0]       erase_done,
    input  logic [NUM_SPRITES-1:0]       draw_done,
    input  logic [X_W*NUM_SPRITES-1:0]   spr_x,
    input  logic [Y_W*NUM_SPRITES-1:0]   spr_y,
    input  logic [C_W*NUM_SPRITES-1:0]   spr_colour,
    input  logic [NUM_SPRITES-1:0]       spr_plot,
    output logic [X_W-1:0]               vga_x,
    output logic [Y_W-1:0]               vga_y,
    output logic [C_W-1:0]               vga_colour,
    output logic                         vga_plot,
`ifdef SEQ_TIMEOUT_EN
    output logic                         timeout_err,
`endif
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overrun
);

    localparam int SW = slot_w(NUM_SPRITES);

    logic [2:0]             state, state_nxt;
    logic [SW-1:0]          slot, slot_nxt;
    logic                   phase_draw, phase_draw_nxt;
    logic [NUM_SPRITES-1:0] en_q, sel_oh, next_oh;
    logic                   cur_en, cur_done, last_slot, in_slot, expired;

    assign sel_oh    = NUM_SPRITES'(1) << slot;
    assign next_oh   = sel_oh << 1;
    assign cur_en    = |(en_q & sel_oh);
    assign cur_done  = phase_draw ? |(draw_done & sel_oh) : |(erase_done & sel_oh);
    assign last_slot = (slot == SW'(NUM_SPRITES - 1));
    assign in_slot   = (state == ST_ERASE_REQ) || (state == ST_ERASE_WAIT) ||
                       (state == ST_DRAW_REQ)  || (state == ST_DRAW_WAIT);

    assign erase_req  = (in_slot && !phase_draw && cur_en) ? sel_oh : '0;
    assign draw_req   = (in_slot &&  phase_draw && cur_en) ? sel_oh : '0;
    assign busy       = (state != ST_IDLE);
    assign frame_done = (state == ST_DONE);

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;

    // Counter is 0 in the *_REQ cycle, so req stays high exactly TIMEOUT_CYCLES cycles.
    assign expired = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            wait_cnt <= ((state_nxt == ST_ERASE_WAIT) || (state_nxt == ST_DRAW_WAIT)) ?
                        wait_cnt + 1'b1 : '0;
            if (in_slot && cur_en && !cur_done && expired)
                timeout_err <= 1'b1;
        end
    end
`else
    assign expired = 1'b0;
`endif

    // ADVANCE retires the current slot and picks the next one; disabled slots
    // cost exactly one ADVANCE cycle each.
    always_comb begin
        state_nxt      = state;
        slot_nxt       = slot;
        phase_draw_nxt = phase_draw;
        case (state)
            ST_IDLE: begin
                if (frame_tick) begin
                    state_nxt      = ST_ERASE_REQ;
                    slot_nxt       = '0;
                    phase_draw_nxt = 1'b0;
                end
            end
            ST_ERASE_REQ, ST_ERASE_WAIT, ST_DRAW_REQ, ST_DRAW_WAIT: begin
                if (!cur_en || cur_done || expired)
                    state_nxt = ST_ADVANCE;
                else if (state == ST_ERASE_REQ)
                    state_nxt = ST_ERASE_WAIT;
                else if (state == ST_DRAW_REQ)
                    state_nxt = ST_DRAW_WAIT;
            end
            ST_ADVANCE: begin
                if (!last_slot) begin
                    slot_nxt  = slot + 1'b1;
                    state_nxt = !(|(en_q & next_oh)) ? ST_ADVANCE :
                                phase_draw ? ST_DRAW_REQ : ST_ERASE_REQ;
                end else if (!phase_draw) begin
                    slot_nxt       = '0;
                    phase_draw_nxt = 1'b1;
                    state_nxt      = en_q[0] ? ST_DRAW_REQ : ST_ADVANCE;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            slot       <= '0;
            phase_draw <= 1'b0;
            en_q       <= '0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            slot       <= slot_nxt;
            phase_draw <= phase_draw_nxt;
            if ((state == ST_IDLE) && frame_tick)
                en_q <= sprite_en;
            // A tick in any non-idle state, DONE included, is dropped.
            if (frame_tick && (state != ST_IDLE))
                overrun <= 1'b1;
        end
    end

    sprite_pixel_mux #(
        .NUM_SPRITES(NUM_SPRITES),
        .SW         (SW)
    ) u_pixel_mux (
        .clk       (clk),
        .reset     (reset),
        .active    ((|erase_req) || (|draw_req)),
        .sel       (slot),
        .spr_x     (spr_x),
        .spr_y     (spr_y),
        .spr_colour(spr_colour),
        .spr_plot  (spr_plot),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_colour(vga_colour),
        .vga_plot  (vga_plot)
    );

endmodule
